// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled LSB-first UART receiver with a one-entry holding register.
// Define UART_RX_PARITY_EN to expect an even-parity bit between the data and stop bits.
module uart_rx #(
    parameter int DBIT       = 8,
    parameter int SB_TICK    = 16,
    parameter int CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            rd,
    output logic [DBIT-1:0] rx_dout,
    output logic            rx_valid,
    output logic            rx_done_tick,
    output logic            frame_err,
    output logic            overrun_err,
    output logic            parity_err
);

    localparam int DIV = CLOCK_FREQ / (BAUD_RATE * 16);
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int NW  = (DBIT > 1) ? $clog2(DBIT) : 1;

    // state  | meaning
    // IDLE   | line idle, waiting for a low level once armed
    // START  | half a start bit, confirming the low level at mid-bit
    // DATA   | shifting in DBIT data bits, LSB first, at mid-bit
    // PARITY | sampling the even-parity bit (UART_RX_PARITY_EN only)
    // STOP   | sampling the stop bit, then commit or discard
`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    logic [CW-1:0]   baud_cnt;
    logic            s_tick;
    logic            rx_meta;
    logic            rx_s;
    logic [1:0]      sync_fill;
    logic            armed;

    state_t          state, state_n;
    logic [3:0]      s_reg, s_n;
    logic [NW-1:0]   n_reg, n_n;
    logic [DBIT-1:0] b_reg, b_n;
    logic            commit;
    logic            ferr;
`ifdef UART_RX_PARITY_EN
    logic            par_bad, par_n;
    logic            perr;
`endif

    assign s_tick = (baud_cnt == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            baud_cnt <= '0;
        end else if (s_tick) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + CW'(1);
        end
    end

    // sync_fill keeps the reset value of the synchronizer from arming the receiver;
    // only a genuinely sampled high line counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta   <= 1'b1;
            rx_s      <= 1'b1;
            sync_fill <= 2'b00;
            armed     <= 1'b0;
        end else begin
            rx_meta   <= rx;
            rx_s      <= rx_meta;
            sync_fill <= {sync_fill[0], 1'b1};
            if (rx_s && sync_fill[1]) begin
                armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            s_reg <= '0;
            n_reg <= '0;
            b_reg <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
`endif
        end else begin
            state <= state_n;
            s_reg <= s_n;
            n_reg <= n_n;
            b_reg <= b_n;
`ifdef UART_RX_PARITY_EN
            par_bad <= par_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        s_n     = s_reg;
        n_n     = n_reg;
        b_n     = b_reg;
        commit  = 1'b0;
        ferr    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_n   = par_bad;
        perr    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!rx_s && armed) begin
                    state_n = START;
                    s_n     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_reg == 4'd7) begin
                        if (!rx_s) begin
                            state_n = DATA;
                            s_n     = '0;
                            n_n     = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        s_n = s_reg + 4'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_reg == 4'd15) begin
                        s_n = '0;
                        b_n = {rx_s, b_reg[DBIT-1:1]};
                        if (n_reg == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state_n = PARITY;
`else
                            state_n = STOP;
`endif
                        end else begin
                            n_n = n_reg + NW'(1);
                        end
                    end else begin
                        s_n = s_reg + 4'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (s_reg == 4'd15) begin
                        s_n     = '0;
                        par_n   = ^{b_reg, rx_s};
                        state_n = STOP;
                    end else begin
                        s_n = s_reg + 4'd1;
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (s_reg == 4'(SB_TICK - 1)) begin
                        state_n = IDLE;
                        s_n     = '0;
                        if (!rx_s) begin
                            ferr = 1'b1;
`ifdef UART_RX_PARITY_EN
                        end else if (par_bad) begin
                            perr = 1'b1;
`endif
                        end else begin
                            commit = 1'b1;
                        end
                    end else begin
                        s_n = s_reg + 4'd1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // A read in the commit clock consumes the old byte, so the new one is not an overrun.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_dout      <= '0;
            rx_valid     <= 1'b0;
            rx_done_tick <= 1'b0;
            frame_err    <= 1'b0;
            overrun_err  <= 1'b0;
        end else begin
            rx_done_tick <= commit;
            frame_err    <= ferr;
            overrun_err  <= commit && rx_valid && !rd;
            if (commit) begin
                rx_dout  <= b_reg;
                rx_valid <= 1'b1;
            end else if (rd) begin
                rx_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= perr;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule
